memory_arbiter: RTL and testbench

Shares one single-ported, variable-latency memory between instruction fetch and the memory stage of the five-stage pipeline. Arbitrates the two requesters, drives a registered request/ready handshake toward the memory, and returns read data plus stall indications to each stage. Data accesses win by default because they belong to the older instruction.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/memory_arbiter_if.sv | 44 ++++
 rtl/memory_arbiter.sv | 139 +++++++++++++
 tb/tb_memory_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types shared across the pipeline: memory arbiter FSM states, access owners
// and the default bus widths.
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch, memory-stage and memory-side signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding pipeline/RAM.
interface memory_arbiter_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              fetch_stall;
    logic              mem_stall;

    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata, ram_ready,
        output if_rdata, if_ready, dm_rdata, dm_ready, fetch_stall, mem_stall,
               ram_req, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata, ram_ready,
        input  if_rdata, if_ready, dm_rdata, dm_ready, fetch_stall, mem_stall,
               ram_req, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one variable-latency memory between fetch and the memory stage; data wins.
// Define ARBITER_STARVATION_GUARD_EN to force a fetch grant after MAX_DATA_BURST data grants.
module memory_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    memory_arbiter_if.master bus
);

    if (MAX_DATA_BURST < 1) begin : g_bad_burst
        $error("MAX_DATA_BURST must be at least 1");
    end

    arb_state_t        state_q, state_d;
    logic              grant;
    owner_t            grant_owner;
    logic              dm_wins;

    logic              ram_req_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

`ifdef ARBITER_STARVATION_GUARD_EN
    localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);

    logic [BURST_W-1:0] burst_q;

    // Fetch overrides data priority once the data side has had its burst.
    assign dm_wins = bus.dm_req && !(bus.if_req && burst_q == BURST_W'(MAX_DATA_BURST));

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= '0;
        end else if (state_q == IDLE) begin
            if (!bus.if_req || (grant && grant_owner == OWN_IF)) begin
                burst_q <= '0;
            end else if (grant && grant_owner == OWN_DM) begin
                burst_q <= burst_q + 1'b1;
            end
        end
    end
`else
    assign dm_wins = bus.dm_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_owner = OWN_DM;
        case (state_q)
            IDLE: begin
                if (dm_wins) begin
                    grant       = 1'b1;
                    grant_owner = OWN_DM;
                    state_d     = BUSY_DM;
                end else if (bus.if_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_IF;
                    state_d     = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (bus.ram_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (grant && grant_owner == OWN_DM) begin
                ram_we_q    <= bus.dm_we;
                ram_addr_q  <= bus.dm_addr;
                ram_wdata_q <= bus.dm_wdata;
            end else if (grant) begin
                ram_we_q    <= 1'b0;
                ram_addr_q  <= bus.if_addr;
            end

            ram_req_q  <= (state_d == BUSY_IF) || (state_d == BUSY_DM);
            if_ready_q <= (state_q == BUSY_IF) && bus.ram_ready;
            dm_ready_q <= (state_q == BUSY_DM) && bus.ram_ready;

            if (state_q == BUSY_IF && bus.ram_ready) begin
                if_rdata_q <= bus.ram_rdata;
            end
            // Stores complete with a ready pulse but leave the load data untouched.
            if (state_q == BUSY_DM && bus.ram_ready && !ram_we_q) begin
                dm_rdata_q <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_req     = ram_req_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.if_ready    = if_ready_q;
    assign bus.dm_ready    = dm_ready_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.fetch_stall = bus.if_req & ~if_ready_q;
    assign bus.mem_stall   = bus.dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: scoreboarded read data, cycle-exact
// handshake checks, and grant-order checks with and without the starvation guard.
module tb_memory_arbiter;
    import cpu_pkg::*;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int MAX_DATA_BURST = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    memory_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] if_exp[$];
    logic [31:0] dm_exp[$];
    bit          sb_en = 1'b1;
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] exp_dm_last = '0;

    int          mem_lat     = 1;
    int          req_cycles  = 0;
    logic        resp_ready  = 1'b0;
    logic        force_ready = 1'b0;
    logic [31:0] resp_rdata  = '0;

    assign bus.ram_ready = resp_ready | force_ready;
    assign bus.ram_rdata = resp_rdata;

    // Memory model: answers after ram_req has been high for mem_lat cycles.
    always @(negedge clk) begin
        resp_ready = 1'b0;
        if (bus.ram_req) begin
            req_cycles = req_cycles + 1;
            if (req_cycles == mem_lat) begin
                resp_ready = 1'b1;
                if (bus.ram_we) begin
                    ram_mem[bus.ram_addr] = bus.ram_wdata;
                    resp_rdata = 32'hBAD0_BAD0;
                end else begin
                    resp_rdata = ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr] : 32'h0;
                end
            end
        end else begin
            req_cycles = 0;
        end
    end

    // Scoreboard: each ready pulse pops the value expected when the request was issued.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (sb_en && bus.if_ready) begin
            n_checks++;
            if (if_exp.size() == 0) begin
                n_fail++;
                $display("FAIL sb_if: unexpected if_ready, if_rdata=%h", bus.if_rdata);
            end else begin
                exp = if_exp.pop_front();
                if (bus.if_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL sb_if_rdata: got %h want %h", bus.if_rdata, exp);
                end
            end
        end
        if (sb_en && bus.dm_ready) begin
            n_checks++;
            if (dm_exp.size() == 0) begin
                n_fail++;
                $display("FAIL sb_dm: unexpected dm_ready, dm_rdata=%h", bus.dm_rdata);
            end else begin
                exp = dm_exp.pop_front();
                if (bus.dm_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL sb_dm_rdata: got %h want %h", bus.dm_rdata, exp);
                end
            end
        end
    end

    task automatic set_mem(input logic [31:0] addr, input logic [31:0] data);
        ref_mem[addr] = data;
        ram_mem[addr] = data;
    endtask

    task automatic issue_fetch(input logic [31:0] addr);
        if_exp.push_back(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0);
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
    endtask

    task automatic issue_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (we) begin
            ref_mem[addr] = wdata;
        end else begin
            exp_dm_last = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        end
        dm_exp.push_back(exp_dm_last);
        bus.dm_we    = we;
        bus.dm_addr  = addr;
        bus.dm_wdata = wdata;
        bus.dm_req   = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        got = {bus.ram_req, bus.ram_we, bus.if_ready, bus.dm_ready, bus.fetch_stall, bus.mem_stall};
        n_checks++;
        if (got !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req/we/rdy/stall bits got %b want 000000", got[5:0]);
        end
        n_checks++;
        if (bus.ram_addr !== 32'h0 || bus.ram_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ram_bus: addr %h wdata %h want 0", bus.ram_addr, bus.ram_wdata);
        end
        n_checks++;
        if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: if %h dm %h want 0", bus.if_rdata, bus.dm_rdata);
        end
    endtask

    task automatic test_lone_fetch();
        mem_lat = 2;
        set_mem(32'h40, 32'h0050_0093);
        @(negedge clk);
        issue_fetch(32'h40);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h40 || bus.ram_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lone_fetch_bus: req %b addr %h we %b want 1 00000040 0",
                             bus.ram_req, bus.ram_addr, bus.ram_we);
                end
                n_checks++;
                if (bus.fetch_stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lone_fetch_stall: got %b want 1", bus.fetch_stall);
                end
            end
            if (c == 2 || c == 4) begin
                n_checks++;
                if (bus.if_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lone_fetch_ready_c%0d: got %b want 0", c, bus.if_ready);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h0050_0093 || bus.fetch_stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lone_fetch_done: ready %b rdata %h stall %b want 1 00500093 0",
                             bus.if_ready, bus.if_rdata, bus.fetch_stall);
                end
                bus.if_req = 1'b0;
            end
        end
    endtask

    task automatic test_simultaneous();
        int dm_at = -1;
        int if_at = -1;
        bit stall_ok = 1'b1;
        mem_lat = 1;
        set_mem(32'h80, 32'h1111_2222);
        @(negedge clk);
        issue_dm(1'b1, 32'h100, 32'hDEAD_BEEF);
        issue_fetch(32'h80);
        for (int c = 1; c <= 20 && if_at < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h100 || bus.ram_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL simul_dm_first: we %b addr %h wdata %h want 1 00000100 deadbeef",
                             bus.ram_we, bus.ram_addr, bus.ram_wdata);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (bus.ram_req !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h80) begin
                    n_fail++;
                    $display("FAIL simul_if_second: req %b we %b addr %h want 1 0 00000080",
                             bus.ram_req, bus.ram_we, bus.ram_addr);
                end
            end
            if (bus.fetch_stall !== !bus.if_ready) stall_ok = 1'b0;
            if (bus.dm_ready) begin
                dm_at = c;
                bus.dm_req = 1'b0;
            end
            if (bus.if_ready) begin
                if_at = c;
                bus.if_req = 1'b0;
            end
        end
        n_checks++;
        if (dm_at != 2 || if_at != 5) begin
            n_fail++;
            $display("FAIL simul_order: dm_ready cycle %0d if_ready cycle %0d want 2 5", dm_at, if_at);
        end
        n_checks++;
        if (!stall_ok) begin
            n_fail++;
            $display("FAIL simul_fetch_stall: got a cycle with fetch_stall != ~if_ready want none");
        end
        n_checks++;
        if (ram_mem[32'h100] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL simul_write: mem[100] got %h want deadbeef", ram_mem[32'h100]);
        end
    endtask

    task automatic test_long_latency();
        bit stable = 1'b1;
        mem_lat = 5;
        set_mem(32'h200, 32'hCAFE_F00D);
        @(negedge clk);
        issue_dm(1'b0, 32'h200, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 5) begin
                if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h200 || bus.mem_stall !== 1'b1 ||
                    bus.dm_ready !== 1'b0) stable = 1'b0;
            end
            if (c == 6) begin
                n_checks++;
                if (bus.dm_ready !== 1'b1 || bus.mem_stall !== 1'b0 || bus.dm_rdata !== 32'hCAFE_F00D) begin
                    n_fail++;
                    $display("FAIL long_lat_done: ready %b stall %b rdata %h want 1 0 cafef00d",
                             bus.dm_ready, bus.mem_stall, bus.dm_rdata);
                end
                bus.dm_req = 1'b0;
            end
            if (c == 7) begin
                n_checks++;
                if (bus.dm_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL long_lat_pulse: dm_ready got %b want 0", bus.dm_ready);
                end
            end
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL long_lat_hold: ram_req/ram_addr/mem_stall not stable over 5 cycles");
        end
    endtask

    task automatic test_write_keeps_rdata();
        bit seen = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        issue_dm(1'b1, 32'h204, 32'h0BAD_F00D);
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.dm_ready) begin
                seen = 1'b1;
                bus.dm_req = 1'b0;
            end
        end
        n_checks++;
        if (!seen || bus.dm_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL write_keeps_rdata: seen %b dm_rdata %h want 1 cafef00d", seen, bus.dm_rdata);
        end
        n_checks++;
        if (ram_mem[32'h204] !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL write_data: mem[204] got %h want 0badf00d", ram_mem[32'h204]);
        end
    endtask

    task automatic test_drop_req();
        bit seen = 1'b0;
        mem_lat = 3;
        set_mem(32'h44, 32'h1234_5678);
        @(negedge clk);
        issue_fetch(32'h44);
        repeat (2) @(negedge clk);
        bus.if_req = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.if_ready) seen = 1'b1;
        end
        n_checks++;
        if (!seen || bus.if_rdata !== 32'h1234_5678 || bus.fetch_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_req: ready seen %b rdata %h stall %b want 1 12345678 0",
                     seen, bus.if_rdata, bus.fetch_stall);
        end
    endtask

    task automatic test_reset_mid_access();
        bit quiet = 1'b1;
        mem_lat = 10;
        set_mem(32'h300, 32'h5555_AAAA);
        @(negedge clk);
        issue_dm(1'b0, 32'h300, 32'h0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL reset_mid_busy: req %b addr %h want 1 00000300", bus.ram_req, bus.ram_addr);
        end
        reset      = 1'b1;
        bus.dm_req = 1'b0;
        dm_exp.delete();
        exp_dm_last = '0;
        @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h0 ||
            bus.dm_ready !== 1'b0 || bus.if_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: req %b we %b addr %h dm_rdy %b if_rdy %b want 0 0 0 0 0",
                     bus.ram_req, bus.ram_we, bus.ram_addr, bus.dm_ready, bus.if_ready);
        end
        n_checks++;
        if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_rdata: if %h dm %h want 0 0", bus.if_rdata, bus.dm_rdata);
        end
        reset       = 1'b0;
        force_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) force_ready = 1'b0;
            if (bus.dm_ready !== 1'b0 || bus.if_ready !== 1'b0 || bus.ram_req !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL reset_mid_stray_ready: ready/ram_req rose after stray ram_ready, want all 0");
        end
    endtask

    task automatic test_starvation();
        int          grants = 0;
        int          cnt    = 0;
        logic        prev_req = 1'b0;
        logic [31:0] exp_addr;
        sb_en   = 1'b0;
        mem_lat = 1;
        set_mem(32'h400, 32'h0000_0400);
        set_mem(32'h500, 32'h0000_0500);
        @(negedge clk);
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h400;
        bus.dm_req  = 1'b1;
        bus.if_addr = 32'h500;
        bus.if_req  = 1'b1;
        for (int c = 1; c <= 200 && grants < 10; c++) begin
            @(negedge clk);
            if (bus.ram_req && !prev_req) begin
`ifdef ARBITER_STARVATION_GUARD_EN
                if (cnt == MAX_DATA_BURST) begin
                    exp_addr = 32'h500;
                    cnt      = 0;
                end else begin
                    exp_addr = 32'h400;
                    cnt++;
                end
`else
                exp_addr = 32'h400;
                cnt++;
`endif
                n_checks++;
                if (bus.ram_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL starvation_grant%0d: ram_addr %h want %h", grants, bus.ram_addr, exp_addr);
                end
                grants++;
            end
            prev_req = bus.ram_req;
        end
        n_checks++;
        if (grants != 10) begin
            n_fail++;
            $display("FAIL starvation_timeout: grants %0d want 10", grants);
        end
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
        repeat (8) @(negedge clk);
        sb_en = 1'b1;
    endtask

    initial begin
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_long_latency();
        test_write_keeps_rdata();
        test_drop_req();
        test_reset_mid_access();
        test_starvation();

        n_checks++;
        if (if_exp.size() != 0 || dm_exp.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: pending if %0d dm %0d want 0 0", if_exp.size(), dm_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
